// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
package if_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 32;

    typedef logic [PC_W_DEF-1:0]    pc_t;
    typedef logic [INSTR_W_DEF-1:0] instr_t;

    // sll $0,$0,0 encodes as all zeros; used as the pipeline bubble.
    localparam instr_t NOP = 32'h0000_0000;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
        logic   valid;
    } ifid_t;

endpackage

// File: rtl/if_pc_gen.sv
// Program counter register with next-PC selection: redirect, hold or increment.
module if_pc_gen #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;

    // Redirect outranks stall so a taken branch is never lost behind a hold.
    always_comb begin
        pc_next = pc_q + PC_W'(PC_STEP);
        if (redirect_i) begin
            pc_next = redirect_pc_i;
        end else if (stall_i) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: PC generation, IF/ID register and free-running cycle counter.
// Optional IF_TRACE_EN macro enables a simulation-only per-cycle fetch trace.
module if_stage_pipe
    import if_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1,
    parameter int              CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } ifid_reg_t;

    logic [PC_W-1:0]  pc;
    ifid_reg_t        ifid_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    if_pc_gen #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc)
    );

    assign imem_addr_o = pc;

    // valid_o qualifies instr_o/pc_o; decode consumes on any edge with valid_o=1 and
    // stall_i=0, while stall_i=1 freezes the slot and redirect_i=1 replaces it with a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.instr <= INSTR_W'(NOP);
            ifid_q.pc    <= '0;
            ifid_q.valid <= 1'b0;
        end else if (redirect_i) begin
            ifid_q.instr <= INSTR_W'(NOP);
            ifid_q.pc    <= '0;
            ifid_q.valid <= 1'b0;
        end else if (!stall_i) begin
            ifid_q.instr <= imem_rdata_i;
            ifid_q.pc    <= pc;
            ifid_q.valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
        end
    end

    assign instr_o     = ifid_q.instr;
    assign pc_o        = ifid_q.pc;
    assign valid_o     = ifid_q.valid;
    assign cycle_cnt_o = cycle_cnt_q;

`ifdef IF_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (redirect_i) begin
                $display("[IF REDIRECT] pc=%h target=%h", pc, redirect_pc_i);
            end else if (stall_i) begin
                $display("[IF STALL] pc=%h", pc);
            end
            $display("pc=%h instr=%b cycle=%0d", pc, imem_rdata_i, cycle_cnt_q);
            $display("----------------------------------------");
        end
    end
`else
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe: reference fetch model plus hand-computed expectations.
module tb_if_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [7:0]  redirect_pc_i;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [7:0]  pc_o;
    logic        valid_o;
    logic [7:0]  cycle_cnt_o;

    int checks = 0;
    int errors = 0;

    if_stage_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .cycle_cnt_o   (cycle_cnt_o)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'h1000_0000 + {24'h0, a};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pipeline expressed directly from the fetch rules.
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic [7:0]  m_pco;
    logic        m_valid;
    logic [7:0]  m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 8'h00;
            m_instr <= 32'h0;
            m_pco   <= 8'h00;
            m_valid <= 1'b0;
            m_cnt   <= 8'h00;
        end else begin
            m_cnt <= m_cnt + 8'd1;
            if (redirect_i) begin
                m_pc    <= redirect_pc_i;
                m_instr <= 32'h0;
                m_pco   <= 8'h00;
                m_valid <= 1'b0;
            end else if (!stall_i) begin
                m_instr <= mem_word(m_pc);
                m_pco   <= m_pc;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 8'd1;
            end
        end
    end

    // scoreboard compare on the inactive edge
    always @(negedge clk) begin
        chk("mdl_imem_addr", {24'h0, imem_addr_o}, {24'h0, m_pc});
        chk("mdl_instr", instr_o, m_instr);
        chk("mdl_pc", {24'h0, pc_o}, {24'h0, m_pco});
        chk("mdl_valid", {31'h0, valid_o}, {31'h0, m_valid});
        chk("mdl_cnt", {24'h0, cycle_cnt_o}, {24'h0, m_cnt});
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 8'h00;
        #12;
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", {24'h0, pc_o}, 32'h0);
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_cnt", {24'h0, cycle_cnt_o}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr_o}, 32'h0);
        rst_n = 1'b1;

        // free run from reset
        step();
        chk("run1_instr", instr_o, 32'h1000_0000);
        chk("run1_pc", {24'h0, pc_o}, 32'h0);
        chk("run1_valid", {31'h0, valid_o}, 32'h1);
        chk("run1_cnt", {24'h0, cycle_cnt_o}, 32'h1);
        step();
        chk("run2_instr", instr_o, 32'h1000_0001);
        chk("run2_pc", {24'h0, pc_o}, 32'h1);
        step();
        chk("run3_instr", instr_o, 32'h1000_0002);
        chk("run3_pc", {24'h0, pc_o}, 32'h2);
        step();
        chk("run4_cnt", {24'h0, cycle_cnt_o}, 32'h4);
        step();
        chk("pre_stall_addr", {24'h0, imem_addr_o}, 32'h5);

        // stall holds everything except the counter
        stall_i = 1'b1;
        repeat (3) step();
        chk("stall_instr", instr_o, 32'h1000_0004);
        chk("stall_pc", {24'h0, pc_o}, 32'h4);
        chk("stall_addr", {24'h0, imem_addr_o}, 32'h5);
        chk("stall_cnt", {24'h0, cycle_cnt_o}, 32'h8);
        stall_i = 1'b0;
        step();
        chk("resume_instr", instr_o, 32'h1000_0005);
        chk("resume_pc", {24'h0, pc_o}, 32'h5);

        // redirect beats a simultaneous stall
        redirect_i    = 1'b1;
        redirect_pc_i = 8'h40;
        stall_i       = 1'b1;
        step();
        chk("redir_valid", {31'h0, valid_o}, 32'h0);
        chk("redir_instr", instr_o, 32'h0);
        chk("redir_addr", {24'h0, imem_addr_o}, 32'h40);
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        step();
        chk("tgt_pc", {24'h0, pc_o}, 32'h40);
        chk("tgt_valid", {31'h0, valid_o}, 32'h1);
        chk("tgt_instr", instr_o, 32'h1000_0040);

        // stall right after the bubble keeps valid low
        redirect_i    = 1'b1;
        redirect_pc_i = 8'h80;
        step();
        redirect_i = 1'b0;
        stall_i    = 1'b1;
        repeat (2) step();
        chk("bubble_stall_valid", {31'h0, valid_o}, 32'h0);
        stall_i = 1'b0;
        step();
        chk("bubble_rel_valid", {31'h0, valid_o}, 32'h1);
        chk("bubble_rel_pc", {24'h0, pc_o}, 32'h80);

        // PC wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 8'hFE;
        step();
        redirect_i = 1'b0;
        step();
        chk("wrap_fe", {24'h0, pc_o}, 32'hFE);
        step();
        chk("wrap_ff", {24'h0, pc_o}, 32'hFF);
        chk("wrap_ff_instr", instr_o, 32'h1000_00FF);
        step();
        chk("wrap_00", {24'h0, pc_o}, 32'h00);
        chk("wrap_00_instr", instr_o, 32'h1000_0000);
        chk("wrap_00_valid", {31'h0, valid_o}, 32'h1);
        step();
        chk("wrap_01", {24'h0, pc_o}, 32'h01);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_instr", instr_o, 32'h0);
        chk("arst_pc", {24'h0, pc_o}, 32'h0);
        chk("arst_valid", {31'h0, valid_o}, 32'h0);
        chk("arst_cnt", {24'h0, cycle_cnt_o}, 32'h0);
        chk("arst_addr", {24'h0, imem_addr_o}, 32'h0);
        #4;
        rst_n = 1'b1;
        step();
        chk("post_rst_instr", instr_o, 32'h1000_0000);
        chk("post_rst_pc", {24'h0, pc_o}, 32'h0);
        chk("post_rst_valid", {31'h0, valid_o}, 32'h1);
        chk("post_rst_cnt", {24'h0, cycle_cnt_o}, 32'h1);

        // counter wrap after 260 edges
        repeat (259) step();
        chk("cnt_wrap", {24'h0, cycle_cnt_o}, 32'h4);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Parametrised instruction-fetch stage for the MIPS32 pipeline.
- Owns the program counter and fetches from an external combinational instruction memory.
- Registers {instruction, PC, valid} into the IF/ID boundary.
- Adds stall, branch/jump redirect with flush, wrap-safe PC increment and a free-running cycle counter, which the earlier fixed 8-bit fetch stage lacked.
- Sits between the hazard/branch unit and the decode stage.

Parameters:
PC_W, 8, PC width in bits; word-addressed PC.
INSTR_W, 32, instruction width in bits.
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 1, PC increment per fetch, in words.
CNT_W, 8, cycle counter width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall_i  input  1  hold PC and IF/ID register.
redirect_i  input  1  branch/jump taken; flush and load new PC.
redirect_pc_i  input  PC_W  redirect target.
imem_addr_o  output  PC_W  instruction memory address; combinational equal to PC register.
imem_rdata_i  input  INSTR_W  instruction memory data; combinational, same cycle.
instr_o  output  INSTR_W  IF/ID instruction.
pc_o  output  PC_W  IF/ID PC of instr_o.
valid_o  output  1  instr_o/pc_o hold a real instruction.
cycle_cnt_o  output  CNT_W  free-running clock counter.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on ports clk and rst_n.
  - While rst_n=0: pc=RESET_PC, instr_o=NOP (all zero), pc_o=0, valid_o=0, cycle_cnt_o=0.
  - Reset asserted mid-operation clears everything immediately, with no dependence on clk.
- Fetch latency: one cycle. The instruction at address A appears on instr_o, with pc_o=A and valid_o=1, on the edge after PC=A.
- Per rising edge, in priority order:
  1. redirect_i=1 (wins over stall_i): pc <= redirect_pc_i; instr_o <= NOP; valid_o <= 0; pc_o <= 0. This is the one bubble after redirect. The target instruction emerges on the following edge.
  2. stall_i=1: pc, instr_o, pc_o and valid_o all hold.
  3. Otherwise: instr_o <= imem_rdata_i; pc_o <= pc; valid_o <= 1; pc <= pc + PC_STEP.
- PC arithmetic: modulo 2^PC_W. With PC_W=8, PC_STEP=1, pc=8'hFF advances to 8'h00 silently.
- cycle_cnt_o: increments every edge regardless of stall/redirect. Wraps modulo 2^CNT_W.
- First post-reset edge with no stall latches the instruction at RESET_PC, valid_o=1.
- Stall released after a redirect bubble: valid_o stays 0 until the first unstalled edge.

Optional Feature:
IF_TRACE_EN.
- Defined: on every edge out of reset, prints PC, the fetched instruction in binary and the cycle count, followed by a separator line. Redirects and stalls are printed as tagged lines. Simulation only.
- Undefined: no $display statements are compiled. Functional behaviour is identical.

Decomposition:
- Package if_pkg holds:
  - pc_t (logic [PC_W-1:0] default width).
  - instr_t.
  - NOP constant (32'h0000_0000, sll $0,$0,0).
  - typedef struct ifid_t {instr, pc, valid}.
- One natural sub-module, if_pc_gen: next-PC mux (redirect / hold / increment) plus the PC register.
- if_stage_pipe instantiates if_pc_gen and the IF/ID register.

Test Plan:
- Reset then 4 free-run cycles, imem returning 32'h1000_0000+addr -> instr_o = 32'h1000_0000, then 32'h1000_0001, then 32'h1000_0002; pc_o 0,1,2; valid_o=1 from first edge; cycle_cnt_o 1..4.
- stall_i=1 for 3 cycles at pc=5 -> instr_o/pc_o frozen at addr 4; imem_addr_o stays 5; cycle_cnt_o keeps counting; resume fetches 5.
- redirect_i=1, redirect_pc_i=8'h40, with stall_i=1 in the same cycle -> next edge valid_o=0, instr_o=0; following edge pc_o=8'h40, valid_o=1.
- pc=8'hFE free-run -> pc_o FE, FF, 00, 01; no glitch on valid_o.
- rst_n pulsed low between edges mid-stream -> outputs zero immediately; after release, fetch restarts at RESET_PC.
- CNT_W=8, 260 cycles -> cycle_cnt_o wraps to 4.
